// File: rtl/squarer_seq_ctrl_8bit.sv
// squarer_seq_ctrl_8bit: sequential squarer, one partial-product row per clock, valid/ready on both sides
module squarer_seq_ctrl_8bit #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_sq,
   output logic               busy,
   output logic [2:0]         row_idx,
   output logic [15:0]        done_count
);
   localparam int AW = 2 * WIDTH;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t            state, nxt;
   logic [WIDTH-1:0]  op_reg;
   logic [AW-1:0]     acc;
   logic [2:0]        row;
   logic              last_row;
   logic [WIDTH-1:0]  low_bits;
   logic [AW-1:0]     term;
   assign last_row  = row == 3'(WIDTH - 1);
   assign low_bits  = op_reg & ((WIDTH'(1) << row) - WIDTH'(1));
   assign term      = op_reg[row] ? ((AW'(1) << {row, 1'b0}) + (AW'(low_bits) << ({1'b0, row} + 4'd1))) : '0;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;
   assign row_idx   = state == ACCUM ? row : 3'd0;
   assign out_sq    = acc;
   // next-state decode: accept in IDLE, sweep rows in ACCUM, wait for consumer in DONE
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = in_valid ? ACCUM : IDLE;
         ACCUM:   nxt = last_row ? DONE : ACCUM;
         DONE:    nxt = out_ready ? IDLE : DONE;
         default: nxt = IDLE;
      endcase
   end
   // state, operand capture, row accumulation and handshake counting
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op_reg     <= '0;
         acc        <= '0;
         row        <= '0;
         done_count <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && in_valid) begin
            op_reg <= in_a;
            acc    <= '0;
            row    <= '0;
         end
         if (state == ACCUM) begin
            acc <= acc + term;
            row <= last_row ? 3'd0 : row + 3'd1;
         end
         if (state == DONE && out_ready) done_count <= done_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_squarer_seq_ctrl_8bit.sv
// tb_squarer_seq_ctrl_8bit: directed self-checking bench for the sequential squarer
module tb_squarer_seq_ctrl_8bit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_sq;
   logic        busy;
   logic [2:0]  row_idx;
   logic [15:0] done_count;
   int n_assert = 0;
   int n_fail = 0;
   squarer_seq_ctrl_8bit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .out_valid(out_valid), .out_ready(out_ready), .out_sq(out_sq), .busy(busy),
      .row_idx(row_idx), .done_count(done_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic reset_dut();
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask
   task automatic run_op(input logic [7:0] a, input logic [15:0] exp, input bit rnd, input int lat);
      int k;
      int g;
      in_a = a;
      in_valid = 1'b1;
      chk("accept_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_a = ~a;
      k = 1;
      while (!out_valid && k < 30) begin
         tick();
         k++;
      end
      chk("valid_timeout", out_valid, 1);
      if (lat > 0) chk("latency", k, lat);
      chk("square", out_sq, exp);
      if (rnd) begin
         g = 0;
         do begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            g++;
            if (out_valid) chk("square_hold", out_sq, exp);
         end while (out_valid && g < 60);
      end else begin
         tick();
      end
      chk("handshake_done", out_valid, 0);
      chk("ready_after_hs", in_ready, 1);
   endtask
   initial begin
      int seen;
      @(negedge clk);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sq", out_sq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_row_idx", row_idx, 0);
      chk("rst_done_count", done_count, 0);
      out_ready = 1'b1;
      run_op(8'h00, 16'h0000, 1'b0, 9);
      run_op(8'h01, 16'h0001, 1'b0, 9);
      run_op(8'h0D, 16'h00A9, 1'b0, 9);
      run_op(8'hFF, 16'hFE01, 1'b0, 9);
      chk("basic_done_count", done_count, 4);
      out_ready = 1'b0;
      in_a = 8'hB7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      seen = 1;
      while (!out_valid && seen < 30) begin
         tick();
         seen++;
      end
      chk("bp_valid", out_valid, 1);
      chk("bp_square", out_sq, 16'h82D1);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_a = 8'h11;
         tick();
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_sq", out_sq, 16'h82D1);
         chk("bp_hold_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      chk("bp_done_count", done_count, 5);
      tick();
      chk("bp_no_capture", busy, 0);
      in_a = 8'h80;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int r = 0; r < 8; r++) begin
         chk("row_idx_step", row_idx, r);
         chk("row_acc_zero", out_sq, 0);
         chk("row_busy", busy, 1);
         tick();
      end
      chk("row_valid", out_valid, 1);
      chk("row_square", out_sq, 16'h4000);
      chk("row_idx_done", row_idx, 0);
      tick();
      chk("row_done_count", done_count, 6);
      reset_dut();
      chk("mid_pre_count", done_count, 0);
      in_a = 8'hFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("mid_row_before_rst", row_idx, 3);
      rst = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_in_ready", in_ready, 1);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_done_count", done_count, 0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen++;
      end
      chk("mid_no_result", seen, 0);
      run_op(8'h03, 16'h0009, 1'b0, 9);
      chk("mid_after_count", done_count, 1);
      reset_dut();
      for (int a = 0; a < 256; a++) run_op(8'(a), 16'(a * a), 1'b1, 9);
      chk("exh_done_count", done_count, 256);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/squarer_seq_ctrl_8bit.md
# squarer_seq_ctrl_8bit

Sequential controller that computes the square of an 8-bit operand by scheduling one partial-product row per clock into a 2·WIDTH-bit accumulator. Row r applies the squarer's partial-product terms: the diagonal term a[r] at weight 2^(2r), and each off-diagonal term a[r]·a[j] (j<r) at weight 2^(r+j+1). The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the time-multiplexed, low-area alternative to the fully parallel squarer.

## Interface
- WIDTH, 8, operand width; legal range 2–8; result width is 2·WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in_a  input  WIDTH  operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sq  output  2·WIDTH  in_a squared.
- busy  output  1  high in ACCUM or DONE.
- row_idx  output  3  current row being accumulated; 0 outside ACCUM.
- done_count  output  16  number of completed output handshakes; wraps modulo 2^16.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_a into op_reg, clear acc, set row=0, and go to ACCUM.
- ACCUM, one row per cycle:
  - acc ← acc + T(row).
  - T(r) = a[r] ? ((1 << 2r) + ((op_reg & ((1<<r)−1)) << (r+1))) : 0, where a = op_reg.
  - row increments each cycle. At row == WIDTH−1, apply the final row and go to DONE.
- DONE:
  - out_valid=1; out_sq=acc, held stable while out_valid & !out_ready.
  - On out_ready: increment done_count and go to IDLE.
- in_ready=0 in ACCUM and DONE. in_valid in those states is ignored, and the operand is not captured.
- Arithmetic:
  - acc is 2·WIDTH bits and never overflows, because the maximum is (2^WIDTH−1)^2.
  - No intermediate sum exceeds the final square, since every term is non-negative.
- in_a is sampled only on the accept edge. Changes to in_a after acceptance have no effect.
- Reset (any state, including mid-ACCUM or DONE with a pending result):
  - Next state is IDLE; the pending result is discarded.
  - acc=0, op_reg=0, row=0, done_count=0.
  - in_ready=1 on the first cycle after the rst edge.
- Simultaneous rst with in_valid or out_ready: rst wins. No acceptance occurs and done_count is not incremented.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_sq=0, busy=0, row_idx=0, done_count=0.
- Latency: with the accept edge at cycle 0, ACCUM occupies cycles 1..WIDTH and out_valid rises in cycle WIDTH+1 (cycle 9 for WIDTH=8).
- Throughput: with out_ready held high, one result per WIDTH+2 cycles. in_ready returns to 1 in the cycle after the output handshake.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid or out_ready to any output.
- out_sq equals acc at all times. It is defined only while out_valid=1.

## Test plan
- **Reset idle:** hold rst 2 cycles, release, no traffic → in_ready=1, out_valid=0, out_sq=0, done_count=0.
- **Basic squares, out_ready tied high:** accept in_a = 0x00, 0x01, 0x0D, 0xFF → out_sq = 0x0000, 0x0001, 0x00A9, 0xFE01. Each out_valid appears exactly 9 cycles after its accept edge. done_count=4 at the end.
- **Exhaustive:** all 256 operands with random out_ready → every out_sq equals a·a and done_count=256.
- **Back-pressure:** accept 0xB7, hold out_ready=0 for 5 cycles → out_valid stays 1 and out_sq stays 0x82D1. in_ready stays 0 and in_valid pulses are ignored. After out_ready=1, in_ready=1 on the next cycle.
- **Reset mid-operation:** accept 0xFF, assert rst in cycle 4 of ACCUM → the next cycle shows IDLE, in_ready=1, out_valid=0, and done_count unchanged at 0. No result for 0xFF is ever presented. A following 0x03 yields 0x0009.
- **Row sequencing:** accept 0x80 → row_idx steps 0..7 during ACCUM and acc stays 0 until row 7, then out_sq=0x4000.
